// File: rtl/time_parameter.sv
// time_parameter: programmable phase durations (tBASE, tEXT, tYEL) for the
// traffic-light controller. The programming side writes one duration per
// rising edge of Prog_Sync. The timer/FSM side reads one duration
// combinationally through interval/value.
// Optional build macro: TIME_PARAM_ZERO_GUARD_EN. When it is defined, a write
// of 0 to a single register loads that register's default instead.
module time_parameter #(
  parameter int unsigned     W          = 4,
  parameter logic [W-1:0]    T_BASE_DEF = 4'd6,
  parameter logic [W-1:0]    T_EXT_DEF  = 4'd3,
  parameter logic [W-1:0]    T_YEL_DEF  = 4'd2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   Selector,
  input  logic [W-1:0] Time_value,
  input  logic         Prog_Sync,
  input  logic [1:0]   interval,
  output logic [W-1:0] value
);

  // Shared encoding for the write target and the read select
  typedef enum logic [1:0] {
    SEL_BASE     = 2'b00,
    SEL_EXT      = 2'b01,
    SEL_YEL      = 2'b10,
    SEL_DEFAULTS = 2'b11
  } sel_e;

  logic         prog_q;
  logic         write_en;
  logic [W-1:0] t_base;
  logic [W-1:0] t_ext;
  logic [W-1:0] t_yel;
  logic [W-1:0] base_wr;
  logic [W-1:0] ext_wr;
  logic [W-1:0] yel_wr;

  // Strobe history used for rising-edge detection. Reset clears it, so a
  // strobe that is already high when reset releases still counts as an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) prog_q <= 1'b0;
    else        prog_q <= Prog_Sync;
  end

  assign write_en = Prog_Sync & ~prog_q;

  // Compute the value each register would take on a single-register write
  always_comb begin
    base_wr = Time_value;
    ext_wr  = Time_value;
    yel_wr  = Time_value;
`ifdef TIME_PARAM_ZERO_GUARD_EN
    if (Time_value == '0) begin
      base_wr = T_BASE_DEF;
      ext_wr  = T_EXT_DEF;
      yel_wr  = T_YEL_DEF;
    end
`endif
  end

  // Duration registers: reset takes priority over a write in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_base <= T_BASE_DEF;
      t_ext  <= T_EXT_DEF;
      t_yel  <= T_YEL_DEF;
    end else if (write_en) begin
      case (sel_e'(Selector))
        SEL_BASE: t_base <= base_wr;
        SEL_EXT:  t_ext  <= ext_wr;
        SEL_YEL:  t_yel  <= yel_wr;
        SEL_DEFAULTS: begin
          t_base <= T_BASE_DEF;
          t_ext  <= T_EXT_DEF;
          t_yel  <= T_YEL_DEF;
        end
        default: ;
      endcase
    end
  end

  // Combinational read mux. Code 11 selects no register and reads as zero.
  always_comb begin
    value = '0;
    case (sel_e'(interval))
      SEL_BASE: value = t_base;
      SEL_EXT:  value = t_ext;
      SEL_YEL:  value = t_yel;
      default:  value = '0;
    endcase
  end

endmodule

// File: tb/tb_time_parameter.sv
// tb_time_parameter: directed vectors for time_parameter. Inputs are driven
// 1 ns after each rising edge and outputs are sampled at the same point.
module tb_time_parameter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] Selector;
  logic [3:0] Time_value;
  logic       Prog_Sync;
  logic [1:0] interval;
  logic [3:0] value;

  int unsigned tests  = 0;
  int unsigned errors = 0;

  time_parameter #(
    .W         (4),
    .T_BASE_DEF(4'd6),
    .T_EXT_DEF (4'd3),
    .T_YEL_DEF (4'd2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Selector  (Selector),
    .Time_value(Time_value),
    .Prog_Sync (Prog_Sync),
    .interval  (interval),
    .value     (value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Select a register to read and compare it after the mux settles
  task automatic read_chk(input string tag, input logic [1:0] sel, input logic [3:0] exp);
    interval = sel;
    #1;
    check(tag, value, exp);
  endtask

  // One complete write: raise the strobe for one cycle, then drop it for one cycle
  task automatic write_pulse(input logic [1:0] sel, input logic [3:0] tv);
    Selector   = sel;
    Time_value = tv;
    Prog_Sync  = 1'b1;
    tick();
    Prog_Sync  = 1'b0;
    tick();
  endtask

  initial begin
    logic [3:0] zero_exp;

    rst_n      = 1'b0;
    Selector   = 2'b00;
    Time_value = 4'd0;
    Prog_Sync  = 1'b0;
    interval   = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset values on every read select
    read_chk("rst_base", 2'b00, 4'd6);
    read_chk("rst_ext",  2'b01, 4'd3);
    read_chk("rst_yel",  2'b10, 4'd2);
    read_chk("rst_none", 2'b11, 4'd0);

    // Write tEXT=10 while reading tBASE
    Selector   = 2'b01;
    interval   = 2'b00;
    Time_value = 4'd10;
    Prog_Sync  = 1'b1;
    tick();
    check("ext_wr_base_view", value, 4'd6);
    read_chk("ext_wr_ext",  2'b01, 4'd10);
    read_chk("ext_wr_yel",  2'b10, 4'd2);
    read_chk("ext_wr_base", 2'b00, 4'd6);

    // A held strobe must not write again
    Time_value = 4'd5;
    tick();
    tick();
    read_chk("held_ext", 2'b01, 4'd10);
    Prog_Sync = 1'b0;
    tick();
    Prog_Sync = 1'b1;
    tick();
    check("rearm_ext", value, 4'd5);
    Prog_Sync = 1'b0;
    tick();

    // Write tBASE and tYEL, then restore all defaults
    write_pulse(2'b00, 4'd12);
    write_pulse(2'b10, 4'd9);
    read_chk("pre_rst_base", 2'b00, 4'd12);
    read_chk("pre_rst_yel",  2'b10, 4'd9);
    read_chk("pre_rst_ext",  2'b01, 4'd5);
    write_pulse(2'b11, 4'd15);
    read_chk("restore_base", 2'b00, 4'd6);
    read_chk("restore_ext",  2'b01, 4'd3);
    read_chk("restore_yel",  2'b10, 4'd2);

    // Reset and a strobe edge arrive in the same cycle: reset wins
    write_pulse(2'b00, 4'd9);
    write_pulse(2'b01, 4'd7);
    read_chk("pre_mid_base", 2'b00, 4'd9);
    Selector   = 2'b00;
    Time_value = 4'd15;
    Prog_Sync  = 1'b1;
    rst_n      = 1'b0;
    tick();
    read_chk("mid_rst_base", 2'b00, 4'd6);
    read_chk("mid_rst_ext",  2'b01, 4'd3);
    // The strobe is still high at release; the cleared history makes that an edge
    rst_n = 1'b1;
    tick();
    read_chk("release_wr_base", 2'b00, 4'd15);
    Prog_Sync = 1'b0;
    tick();

    // Writing 0 to tYEL
`ifdef TIME_PARAM_ZERO_GUARD_EN
    zero_exp = 4'd2;
`else
    zero_exp = 4'd0;
`endif
    write_pulse(2'b10, 4'd7);
    read_chk("yel_seven", 2'b10, 4'd7);
    write_pulse(2'b10, 4'd0);
    read_chk("zero_yel", 2'b10, zero_exp);
    read_chk("zero_base_hold", 2'b00, 4'd15);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/time_parameter.md
Name: time_parameter

Overview:
- Holds the three programmable durations of the traffic-light controller, in seconds: base green (tBASE), extended green (tEXT) and yellow (tYEL).
- The FSM/timer side selects one duration via `interval` and reads it combinationally on `value`.
- The operator/programming side rewrites one duration at a time via `Selector`, `Time_value` and the synchronized strobe `Prog_Sync`.
- Sits between the input synchronizers and the timer/FSM.

Parameters:
- T_BASE_DEF, 4'd6, reset/default value of tBASE.
- T_EXT_DEF, 4'd3, reset/default value of tEXT.
- T_YEL_DEF, 4'd2, reset/default value of tYEL.
- W, 4, width of every duration register, `Time_value` and `value`.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- Selector  in  2  target of a write: 00 tBASE, 01 tEXT, 10 tYEL, 11 restore all defaults.
- Time_value  in  W  new duration to store.
- Prog_Sync  in  1  synchronized program strobe; a write occurs on its rising edge.
- interval  in  2  read select: 00 tBASE, 01 tEXT, 10 tYEL, 11 none.
- value  out  W  selected duration.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-low: sampled only on a rising clk edge while rst_n=0.
- Reset state:
  - tBASE=T_BASE_DEF, tEXT=T_EXT_DEF, tYEL=T_YEL_DEF.
  - Internal strobe history prog_q=0.
  - Reset takes priority over any write in the same cycle.
- Edge detect:
  - prog_q registers Prog_Sync every cycle.
  - write_en = Prog_Sync & ~prog_q.
  - Holding Prog_Sync high performs exactly one write; a new write needs Prog_Sync to return to 0 for at least one cycle.
- Write (on the clk edge where write_en=1):
  - Selector=00: tBASE <= Time_value.
  - Selector=01: tEXT <= Time_value.
  - Selector=10: tYEL <= Time_value.
  - Selector=11: all three registers return to their defaults; Time_value is ignored.
  - Selector and Time_value are sampled only on that edge. Changes while Prog_Sync stays high have no effect.
- Read path (purely combinational, no latency):
  - interval=00 -> tBASE; 01 -> tEXT; 10 -> tYEL; 11 -> 0.
  - After a write to the register selected by interval, value shows the new content right after the same clk edge.
- No wrap or arithmetic; values are stored unmodified, 0..15.
- Prog_Sync already high when reset releases: prog_q was cleared by reset, so the first cycle after reset counts as a rising edge and a write occurs.
- Registers not targeted by a write hold their value.

Optional Feature:
- Macro TIME_PARAM_ZERO_GUARD_EN.
- Defined:
  - A write with Selector in 00..10 and Time_value=0 does not store 0. The target register is loaded with its default (T_*_DEF) instead, so the controller can never be programmed with a zero-length phase.
  - Selector=11 is unaffected.
- Undefined: a Time_value of 0 is stored as-is.

Test Plan:
- Reset: hold rst_n=0 for 2 edges, then release with interval=00 / 01 / 10 / 11 -> value = 6 / 3 / 2 / 0.
- Write tEXT:
  - Stimulus: after reset, Selector=01, interval=00; at t=25 ns Time_value=4'b1010; at t=27 ns Prog_Sync=1 and held high.
  - Required: value stays 6.
  - Then switch interval to 01 -> value=10; tBASE=6 and tYEL=2 unchanged.
- Held strobe:
  - Stimulus: keep Prog_Sync=1 and change Time_value to 5 on the next cycle.
  - Required: tEXT stays 10.
  - Drop Prog_Sync for 1 cycle, then raise it with Time_value=5 -> tEXT=5.
- Restore: tBASE=12, tYEL=9 written, then Selector=11 write pulse -> interval 00/01/10 read 6/3/2.
- Reset mid-operation: rst_n=0 on the same edge as a Prog_Sync rising edge with Selector=00, Time_value=15 -> tBASE=6 after the edge, and no write occurs.
- Zero guard: Selector=10, Time_value=0, write pulse -> tYEL=0 without the macro; tYEL=2 with TIME_PARAM_ZERO_GUARD_EN defined.
